// File: rtl/ula_pkg.sv
// Shared definitions for the ALU command queue: opcodes, FSM encoding,
// the queued command layout and the trap rules.
package ula_pkg;

    localparam logic [3:0] OP_SOMA = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] EXECUTA = 2'd1;
    localparam logic [1:0] ENTREGA = 2'd2;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    // 0101 and 11xx have no ALU function assigned
    function automatic logic op_invalido(input logic [3:0] op);
        return (op == 4'b0101) || (op[3:2] == 2'b11);
    endfunction

    function automatic logic cmd_armadilha(input cmd_t c);
        return op_invalido(c.op) || (((c.op == OP_DIV) || (c.op == OP_MOD)) && (c.b == 8'h00));
    endfunction

endpackage

// File: rtl/ula_fila_cmd_if.sv
// Bundle of the command, ALU and result handshakes around the issue stage.
interface ula_fila_cmd_if #(
    parameter int PROFUNDIDADE = 4
);
    localparam int OW = $clog2(PROFUNDIDADE) + 1;

    logic          cmd_valido;
    logic          cmd_pronto;
    logic [3:0]    cmd_op;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic [7:0]    ula_A;
    logic [7:0]    ula_B;
    logic [3:0]    ula_Sel_Op;
    logic [15:0]   ula_Resultado;
    logic          ula_Maior;
    logic          ula_Menor;
    logic          ula_Igual;
    logic          res_valido;
    logic          res_pronto;
    logic [15:0]   res_dado;
    logic [2:0]    res_flags;
    logic          res_erro;
    logic [OW-1:0] ocupacao;

    modport slave (
        input  cmd_valido, cmd_op, cmd_a, cmd_b,
        input  ula_Resultado, ula_Maior, ula_Menor, ula_Igual,
        input  res_pronto,
        output cmd_pronto, ula_A, ula_B, ula_Sel_Op,
        output res_valido, res_dado, res_flags, res_erro, ocupacao
    );

    modport master (
        output cmd_valido, cmd_op, cmd_a, cmd_b,
        output ula_Resultado, ula_Maior, ula_Menor, ula_Igual,
        output res_pronto,
        input  cmd_pronto, ula_A, ula_B, ula_Sel_Op,
        input  res_valido, res_dado, res_flags, res_erro, ocupacao
    );
endinterface

// File: rtl/ula_fifo.sv
// Synchronous FIFO with wrapping pointers; occupancy carries the extra bit
// that separates full from empty. The ready flag is registered.
module ula_fifo #(
    parameter int LARGURA      = 20,
    parameter int PROFUNDIDADE = 4,
    localparam int PW          = $clog2(PROFUNDIDADE),
    localparam int OW          = PW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [LARGURA-1:0] din,
    input  logic               pop,
    output logic [LARGURA-1:0] dout,
    output logic [OW-1:0]      ocupacao,
    output logic               vazia,
    output logic               pronto
);
    localparam logic [OW-1:0] CHEIO = OW'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [OW-1:0]      ocupacao_reg;
    logic [OW-1:0]      ocupacao_next;
    logic               pronto_reg;
    logic               push_ef;
    logic               pop_ef;

    assign vazia   = (ocupacao_reg == '0);
    assign push_ef = push && pronto_reg;
    assign pop_ef  = pop && !vazia;

    always_comb begin
        ocupacao_next = ocupacao_reg;
        case ({push_ef, pop_ef})
            2'b10:   ocupacao_next = ocupacao_reg + OW'(1);
            2'b01:   ocupacao_next = ocupacao_reg - OW'(1);
            default: ocupacao_next = ocupacao_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ef) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ocupacao_reg <= '0;
            pronto_reg   <= 1'b0;
        end else begin
            if (push_ef) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ef)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            ocupacao_reg <= ocupacao_next;
            pronto_reg   <= (ocupacao_next != CHEIO);
        end
    end

    assign dout     = mem[rd_ptr_reg];
    assign ocupacao = ocupacao_reg;
    assign pronto   = pronto_reg;
endmodule

// File: rtl/ula_fila_cmd.sv
// Issue stage in front of the combinational ALU: queues commands, holds one
// in the operand register, registers the ALU answer and hands it downstream.
module ula_fila_cmd
    import ula_pkg::*;
#(
    parameter int PROFUNDIDADE = 4
) (
    input logic           clk,
    input logic           rst_n,
    ula_fila_cmd_if.slave barramento
);
    localparam int OW = $clog2(PROFUNDIDADE) + 1;

    cmd_t          entrada;
    cmd_t          cabeca;
    cmd_t          operando_reg;
    logic [1:0]    estado_reg;
    logic          push;
    logic          pop;
    logic          vazia;
    logic          pronto;
    logic [OW-1:0] ocupacao;
    logic          valido_reg;
    logic [15:0]   dado_reg;
    logic [15:0]   dado_next;
    logic [2:0]    flags_reg;
    logic          erro_reg;
    logic          armadilha;

    assign entrada = '{op: barramento.cmd_op, a: barramento.cmd_a, b: barramento.cmd_b};
    assign push    = barramento.cmd_valido && pronto;
    assign pop     = !vazia && ((estado_reg == OCIOSO) ||
                                ((estado_reg == ENTREGA) && barramento.res_pronto));

    ula_fifo #(
        .LARGURA      ($bits(cmd_t)),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (entrada),
        .pop      (pop),
        .dout     (cabeca),
        .ocupacao (ocupacao),
        .vazia    (vazia),
        .pronto   (pronto)
    );

    // Only multiply produces a meaningful upper byte
    always_comb begin
        armadilha = cmd_armadilha(operando_reg);
        dado_next = {8'h00, barramento.ula_Resultado[7:0]};
        if (armadilha) begin
            dado_next = 16'h0000;
        end else if (operando_reg.op == OP_MUL) begin
            dado_next = barramento.ula_Resultado;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg   <= OCIOSO;
            operando_reg <= '0;
            valido_reg   <= 1'b0;
            dado_reg     <= '0;
            flags_reg    <= '0;
            erro_reg     <= 1'b0;
        end else begin
            case (estado_reg)
                OCIOSO: begin
                    if (pop) begin
                        operando_reg <= cabeca;
                        estado_reg   <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    valido_reg <= 1'b1;
                    dado_reg   <= dado_next;
                    erro_reg   <= armadilha;
                    flags_reg  <= {barramento.ula_Maior, barramento.ula_Menor, barramento.ula_Igual};
                    estado_reg <= ENTREGA;
                end
                ENTREGA: begin
                    if (barramento.res_pronto) begin
                        valido_reg <= 1'b0;
                        if (pop) begin
                            operando_reg <= cabeca;
                            estado_reg   <= EXECUTA;
                        end else begin
                            estado_reg <= OCIOSO;
                        end
                    end
                end
                default: estado_reg <= OCIOSO;
            endcase
        end
    end

    assign barramento.cmd_pronto = pronto;
    assign barramento.ocupacao   = ocupacao;
    assign barramento.ula_A      = operando_reg.a;
    assign barramento.ula_B      = operando_reg.b;
    assign barramento.ula_Sel_Op = operando_reg.op;
    assign barramento.res_valido = valido_reg;
    assign barramento.res_dado   = dado_reg;
    assign barramento.res_flags  = flags_reg;
    assign barramento.res_erro   = erro_reg;
endmodule

// File: tb/tb_ula_fila_cmd.sv
// Directed bench for the ALU command queue with a behavioural ALU and a
// scoreboard of expected {dado, flags, erro} popped on each result handshake.
module tb_ula_fila_cmd;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [19:0] sb [$];

    always #5 clk = ~clk;

    ula_fila_cmd_if #(.PROFUNDIDADE(4)) bus ();

    ula_fila_cmd #(.PROFUNDIDADE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .barramento (bus)
    );

    // Behavioural stand-in for the combinational ALU wired above this block
    always_comb begin
        bus.ula_Resultado = 16'h0000;
        case (bus.ula_Sel_Op)
            OP_SOMA: bus.ula_Resultado = {8'h00, bus.ula_A} + {8'h00, bus.ula_B};
            OP_SUB:  bus.ula_Resultado = {8'h00, bus.ula_A} - {8'h00, bus.ula_B};
            OP_MUL:  bus.ula_Resultado = {8'h00, bus.ula_A} * {8'h00, bus.ula_B};
            OP_DIV:  bus.ula_Resultado = (bus.ula_B == 8'h00) ? 16'h0000 : {8'h00, bus.ula_A / bus.ula_B};
            OP_MOD:  bus.ula_Resultado = (bus.ula_B == 8'h00) ? 16'h0000 : {8'h00, bus.ula_A % bus.ula_B};
            OP_AND:  bus.ula_Resultado = {8'h00, bus.ula_A & bus.ula_B};
            OP_OR:   bus.ula_Resultado = {8'h00, bus.ula_A | bus.ula_B};
            OP_NAND: bus.ula_Resultado = {8'h00, ~(bus.ula_A & bus.ula_B)};
            OP_NOR:  bus.ula_Resultado = {8'h00, ~(bus.ula_A | bus.ula_B)};
            OP_XOR:  bus.ula_Resultado = {8'h00, bus.ula_A ^ bus.ula_B};
            OP_NOT:  bus.ula_Resultado = {8'h00, ~bus.ula_A};
            default: bus.ula_Resultado = 16'hFFFF;
        endcase
        bus.ula_Maior = (bus.ula_A > bus.ula_B);
        bus.ula_Menor = (bus.ula_A < bus.ula_B);
        bus.ula_Igual = (bus.ula_A == bus.ula_B);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] saidas();
        return {19'd0, bus.cmd_pronto, bus.ula_A, bus.ula_B, bus.ula_Sel_Op, bus.res_valido,
                bus.res_dado, bus.res_flags, bus.res_erro, bus.ocupacao};
    endfunction

    // Result monitor: a handshake completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && bus.res_valido && bus.res_pronto) begin
            if (sb.size() == 0) begin
                chk("resultado_inesperado", bus.res_valido, 0);
            end else begin
                logic [19:0] esp;
                esp = sb.pop_front();
                chk("resultado", {bus.res_dado, bus.res_flags, bus.res_erro}, esp);
                $display("result dado=%0d flags=%b erro=%b expected=%0h", bus.res_dado, bus.res_flags, bus.res_erro, esp);
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accepting edge
    task automatic enviar(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] dado, input logic [2:0] flags, input logic erro);
        logic aceito;
        bus.cmd_op     = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_valido = 1'b1;
        aceito = 1'b0;
        for (int i = 0; i < 40 && !aceito; i++) begin
            aceito = bus.cmd_pronto;
            @(posedge clk);
            #1;
        end
        chk("aceite", aceito, 1);
        if (aceito) sb.push_back({dado, flags, erro});
        $display("push op=%b a=%0d b=%0d accepted=%b", op, a, b, aceito);
    endtask

    task automatic esperar_valido(input string tag);
        logic visto;
        visto = 1'b0;
        for (int i = 0; i < 20 && !visto; i++) begin
            if (bus.res_valido) visto = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk(tag, visto, 1);
    endtask

    task automatic esperar_vazio(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valido = 1'b0;
        bus.cmd_op     = 4'h0;
        bus.cmd_a      = 8'h00;
        bus.cmd_b      = 8'h00;
        bus.res_pronto = 1'b1;

        // Reset state and cmd_pronto rising on the first edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("reset_saidas", saidas(), 0);
        rst_n = 1'b1;
        #1;
        chk("pronto_antes_borda", bus.cmd_pronto, 0);
        @(posedge clk);
        #1;
        chk("pronto_apos_borda", bus.cmd_pronto, 1);

        // Latency: accept at t, pop at t+1, valid after t+2
        enviar(OP_SOMA, 8'd50, 8'd30, 16'd80, 3'b100, 1'b0);
        bus.cmd_valido = 1'b0;
        chk("latencia_t1", bus.res_valido, 0);
        @(posedge clk);
        #1;
        chk("latencia_t2_ula_op", {bus.ula_Sel_Op, bus.ula_A, bus.ula_B}, {OP_SOMA, 8'd50, 8'd30});
        chk("latencia_t2", bus.res_valido, 0);
        @(posedge clk);
        #1;
        chk("latencia_t3", bus.res_valido, 1);
        esperar_vazio("dreno_soma");

        // Back-to-back: one-cycle gap between results
        enviar(OP_MUL, 8'd20, 8'd20, 16'd400, 3'b001, 1'b0);
        enviar(OP_DIV, 8'd100, 8'd5, 16'd20, 3'b100, 1'b0);
        bus.cmd_valido = 1'b0;
        esperar_valido("valido_primeiro");
        @(posedge clk);
        #1;
        chk("lacuna_baixa", bus.res_valido, 0);
        @(posedge clk);
        #1;
        chk("segundo_valido", bus.res_valido, 1);
        esperar_vazio("dreno_mul_div");

        // Trapped commands
        enviar(OP_DIV, 8'd7, 8'd0, 16'd0, 3'b100, 1'b1);
        enviar(4'b1111, 8'd1, 8'd1, 16'd0, 3'b001, 1'b1);
        bus.cmd_valido = 1'b0;
        esperar_vazio("dreno_armadilha");

        // Fill: one in flight plus four queued
        bus.res_pronto = 1'b0;
        enviar(OP_SOMA, 8'd1, 8'd2, 16'd3, 3'b010, 1'b0);
        enviar(OP_SUB, 8'd9, 8'd4, 16'd5, 3'b100, 1'b0);
        enviar(OP_AND, 8'hF0, 8'h3C, 16'h0030, 3'b100, 1'b0);
        enviar(OP_XOR, 8'hAA, 8'hAA, 16'h0000, 3'b001, 1'b0);
        enviar(OP_NOT, 8'h0F, 8'h00, 16'h00F0, 3'b100, 1'b0);
        bus.cmd_valido = 1'b0;
        chk("cheio_ocupacao", bus.ocupacao, 4);
        chk("cheio_pronto", bus.cmd_pronto, 0);
        chk("cheio_em_voo", bus.res_valido, 1);
        chk("cheio_ula_A", bus.ula_A, 8'd1);
        @(posedge clk);
        #1;
        chk("cheio_estavel", {bus.res_dado, bus.res_flags, bus.res_erro}, {16'd3, 3'b010, 1'b0});
        bus.res_pronto = 1'b1;
        esperar_vazio("dreno_cheio");

        // Asynchronous reset during ENTREGA with two queued
        bus.res_pronto = 1'b0;
        enviar(OP_SOMA, 8'd3, 8'd4, 16'd7, 3'b010, 1'b0);
        enviar(OP_OR, 8'd1, 8'd2, 16'd3, 3'b010, 1'b0);
        enviar(OP_NAND, 8'd5, 8'd5, 16'h00FA, 3'b001, 1'b0);
        bus.cmd_valido = 1'b0;
        esperar_valido("entrega_antes_reset");
        chk("ocupacao_antes_reset", bus.ocupacao, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_assincrono", saidas(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mantido", saidas(), 0);
        rst_n = 1'b1;
        bus.res_pronto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("sem_resultado_velho", {bus.res_valido, bus.ocupacao}, 0);
        end
        chk("pronto_pos_reset", bus.cmd_pronto, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
